// File: rtl/mem_initiator.sv
// mem_initiator: burst command initiator for a single-port synchronous memory.
// Define MEM_INIT_VERIFY_EN to add a read-back verify cycle after every write.
module mem_initiator #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              verify_err,
    output logic              ce_mem,
    output logic              we_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] datai_mem,
    input  logic [DATA_W-1:0] datao_mem
);

`ifdef MEM_INIT_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE, WRITE, READ, DRAIN, VERIFY
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, WRITE, READ, DRAIN
    } state_t;
`endif

    state_t state;
    state_t state_d;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W-1:0]  left;
    logic [LEN_W-1:0]  left_d;
    logic              last;
    logic              last_d;
    logic              dcnt;
    logic              dcnt_d;
    logic              ce_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_mem_d;
    logic [DATA_W-1:0] datai_d;
    logic              ready_q;
    logic              pend;
    logic              accept;
    logic              take;

    assign accept    = cmd_valid & cmd_ready;
    assign take      = wr_valid & wr_ready;
    assign busy      = (state != IDLE);
    assign cmd_ready = ready_q & (state == IDLE);

`ifdef MEM_INIT_VERIFY_EN
    logic cmp_d;
    logic cmp_pend;
    // The issue cycle itself blocks new beats so VERIFY can follow it.
    assign wr_ready = (state == WRITE) & ~last & ~ce_mem;
`else
    assign wr_ready   = (state == WRITE) & ~last;
    assign verify_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d = cmd_we ? WRITE : READ;
                end
            end
            READ: begin
                if (left == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!dcnt) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
`ifdef MEM_INIT_VERIFY_EN
                if (ce_mem) begin
                    state_d = VERIFY;
                end
`else
                if (last) begin
                    state_d = IDLE;
                end
`endif
            end
`ifdef MEM_INIT_VERIFY_EN
            VERIFY: begin
                state_d = last ? DRAIN : WRITE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        ce_d       = 1'b0;
        we_d       = 1'b0;
        addr_mem_d = addr_mem;
        datai_d    = datai_mem;
        addr_d     = addr;
        left_d     = left;
        last_d     = last;
        dcnt_d     = dcnt;
`ifdef MEM_INIT_VERIFY_EN
        cmp_d      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (accept) begin
                    left_d = cmd_len;
                    last_d = 1'b0;
                    if (cmd_we) begin
                        addr_d = cmd_addr;
                    end else begin
                        // First read beat goes out right away.
                        ce_d       = 1'b1;
                        addr_mem_d = cmd_addr;
                        addr_d     = cmd_addr + ADDR_W'(1);
                    end
                end
            end
            READ: begin
                if (left == '0) begin
                    dcnt_d = 1'b1;
                end else begin
                    ce_d       = 1'b1;
                    addr_mem_d = addr;
                    addr_d     = addr + ADDR_W'(1);
                    left_d     = left - LEN_W'(1);
                end
            end
            DRAIN: begin
                dcnt_d = 1'b0;
            end
            WRITE: begin
`ifdef MEM_INIT_VERIFY_EN
                if (ce_mem) begin
                    ce_d = 1'b1;
                end else if (take) begin
`else
                if (take) begin
`endif
                    ce_d       = 1'b1;
                    we_d       = 1'b1;
                    addr_mem_d = addr;
                    datai_d    = wr_data;
                    addr_d     = addr + ADDR_W'(1);
                    if (left == '0) begin
                        last_d = 1'b1;
                    end else begin
                        left_d = left - LEN_W'(1);
                    end
                end
            end
`ifdef MEM_INIT_VERIFY_EN
            VERIFY: begin
                cmp_d  = 1'b1;
                dcnt_d = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // Registered memory pins and read return path
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready_q   <= 1'b0;
            ce_mem    <= 1'b0;
            we_mem    <= 1'b0;
            addr_mem  <= '0;
            datai_mem <= '0;
            addr      <= '0;
            left      <= '0;
            last      <= 1'b0;
            dcnt      <= 1'b0;
            pend      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            ready_q   <= 1'b1;
            ce_mem    <= ce_d;
            we_mem    <= we_d;
            addr_mem  <= addr_mem_d;
            datai_mem <= datai_d;
            addr      <= addr_d;
            left      <= left_d;
            last      <= last_d;
            dcnt      <= dcnt_d;
            pend      <= (state == READ);
            rd_valid  <= pend;
            if (pend) begin
                rd_data <= datao_mem;
            end
        end
    end

`ifdef MEM_INIT_VERIFY_EN
    // datai_mem still holds the beat just verified.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmp_pend   <= 1'b0;
            verify_err <= 1'b0;
        end else begin
            cmp_pend <= cmp_d;
            if (cmp_pend && (datao_mem != datai_mem)) begin
                verify_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: randomized bench with a memory core model and a
// reference memory image for mem_initiator.
module tb_mem_initiator;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       verify_err;
    logic       ce_mem;
    logic       we_mem;
    logic [7:0] addr_mem;
    logic [7:0] datai_mem;
    logic [7:0] datao_mem = 8'h00;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [7:0] exp_mem [256];
    logic [7:0] core    [256];
    logic       load = 1'b0;
    logic       corrupt_en = 1'b0;
    logic [7:0] corrupt_addr = 8'h00;
    logic [7:0] wd [16];
    logic [7:0] wq_addr [$];
    int         wq_cyc  [$];

    mem_initiator dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .busy       (busy),
        .verify_err (verify_err),
        .ce_mem     (ce_mem),
        .we_mem     (we_mem),
        .addr_mem   (addr_mem),
        .datai_mem  (datai_mem),
        .datao_mem  (datao_mem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory core: one-cycle read latency, optional read corruption
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) core[i] <= exp_mem[i];
        end else if (ce_mem) begin
            if (we_mem) core[addr_mem] <= datai_mem;
            else datao_mem <= core[addr_mem] ^
                ((corrupt_en && addr_mem == corrupt_addr) ? 8'h01 : 8'h00);
        end
    end

    always @(negedge clk) begin
        if (ce_mem && we_mem) begin
            wq_addr.push_back(addr_mem);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_cmd(input logic we, input logic [7:0] a,
                              input int n, output bit ok);
        int t;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = 4'(n - 1);
        t = 0;
        while (!cmd_ready && t < 50) begin
            step();
            t++;
        end
        vectors++;
        ok = cmd_ready;
        if (!ok) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 100) begin
            step();
            t++;
        end
        vectors++;
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input int n,
                            input int gap_at, input int gap_len,
                            input bit rnd_gap);
        int  i, g, t;
        bit  ok, taken;
        logic [7:0] ea;
        accept_cmd(1'b1, a, n, ok);
        if (!ok) return;
        i = 0;
        g = 0;
        t = 0;
        while (i < n && t < 300) begin
            if (i == gap_at && g < gap_len) begin
                wr_valid = 1'b0;
                g++;
            end else if (rnd_gap && $urandom_range(3) == 0) begin
                wr_valid = 1'b0;
            end else begin
                wr_valid = 1'b1;
                wr_data  = wd[i];
            end
            taken = wr_valid && wr_ready;
            step();
            t++;
            if (taken) i++;
        end
        wr_valid = 1'b0;
        vectors++;
        if (i != n) begin
            errors++;
            $display("FAIL wr_beats: taken=%0d required %0d", i, n);
        end
        wait_idle();
        for (int k = 0; k < n; k++) begin
            ea = 8'(a + k);
            exp_mem[ea] = wd[k];
            vectors++;
            if (core[ea] !== wd[k]) begin
                errors++;
                $display("FAIL wr_mem[%02h]: got %02h required %02h",
                         ea, core[ea], wd[k]);
            end
        end
    endtask

    task automatic do_read(input logic [7:0] a, input int n);
        int  t, beats;
        bit  ok;
        logic [7:0] e;
        accept_cmd(1'b0, a, n, ok);
        if (!ok) return;
        beats = 0;
        for (t = 1; t <= n + 8; t++) begin
            if (rd_valid) begin
                e = exp_mem[8'(a + beats)];
                vectors++;
                if (rd_data !== e || t != 3 + beats) begin
                    errors++;
                    $display("FAIL rd_beat%0d: data %02h at t%0d required %02h at t%0d",
                             beats, rd_data, t, e, 3 + beats);
                end
                beats++;
            end
            step();
        end
        vectors++;
        if (beats != n || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_count: beats=%0d busy=%b required %0d/0",
                     beats, busy, n);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 8'h00;
        cmd_len   = 4'h0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'($urandom);
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        vectors++;
        if ({cmd_ready, wr_ready, rd_valid, rd_data, busy, verify_err,
             ce_mem, we_mem, addr_mem, datai_mem} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero (ce=%b busy=%b rdy=%b)",
                     ce_mem, busy, cmd_ready);
        end
        reset = 1'b1;
        step();
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b required 1/0",
                     cmd_ready, busy);
        end
    endtask

    task automatic test_single();
        wd[0] = 8'hA5;
        do_write(8'h10, 1, -1, 0, 1'b0);
        do_read(8'h10, 1);
    endtask

    task automatic test_wrap();
        wd[0] = 8'h11;
        wd[1] = 8'h22;
        wd[2] = 8'h33;
        wd[3] = 8'h44;
        do_write(8'hFE, 4, -1, 0, 1'b0);
        do_read(8'hFE, 4);
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 4; i++) wd[i] = 8'($urandom);
        wq_addr.delete();
        wq_cyc.delete();
        do_write(8'h40, 4, 2, 2, 1'b0);
        vectors++;
        if (wq_addr.size() != 4) begin
            errors++;
            $display("FAIL gap_issues: count=%0d required 4", wq_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (wq_addr[i] !== 8'(8'h40 + i)) begin
                    errors++;
                    $display("FAIL gap_addr%0d: got %02h required %02h",
                             i, wq_addr[i], 8'(8'h40 + i));
                end
            end
`ifndef MEM_INIT_VERIFY_EN
            vectors++;
            if (wq_cyc[3] - wq_cyc[0] != 5) begin
                errors++;
                $display("FAIL gap_span: span=%0d required 5",
                         wq_cyc[3] - wq_cyc[0]);
            end
`endif
        end
        do_read(8'h40, 4);
    endtask

    task automatic test_cmd_ignored();
        logic [7:0] eq [$];
        bit  ok, acc2, go;
        int  bad, beats, acc_t;
        logic [7:0] e;
        wq_addr.delete();
        for (int i = 0; i < 4; i++) eq.push_back(exp_mem[8'(8'h80 + i)]);
        eq.push_back(exp_mem[8'h20]);
        accept_cmd(1'b0, 8'h80, 4, ok);
        if (!ok) return;
        cmd_valid = 1'b1;
        cmd_addr  = 8'h20;
        cmd_len   = 4'h0;
        wr_valid  = 1'b1;
        wr_data   = 8'($urandom);
        bad = 0;
        beats = 0;
        acc2 = 1'b0;
        acc_t = 0;
        for (int t = 1; t <= 20; t++) begin
            if (busy && cmd_ready) bad++;
            if (rd_valid) begin
                e = (beats < 5) ? eq[beats] : 8'h00;
                vectors++;
                if (beats >= 5 || rd_data !== e) begin
                    errors++;
                    $display("FAIL ign_beat%0d: got %02h required %02h",
                             beats, rd_data, e);
                end
                beats++;
            end
            go = cmd_valid && cmd_ready && !acc2;
            step();
            if (go) begin
                acc2 = 1'b1;
                acc_t = t;
                cmd_valid = 1'b0;
            end
        end
        wr_valid = 1'b0;
        vectors++;
        if (bad != 0 || acc_t != 7 || beats != 5) begin
            errors++;
            $display("FAIL ign_cmd: bad=%0d acc_t=%0d beats=%0d required 0/7/5",
                     bad, acc_t, beats);
        end
        vectors++;
        if (wq_addr.size() != 0) begin
            errors++;
            $display("FAIL ign_wr: writes=%0d required 0", wq_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int beats, late;
        accept_cmd(1'b0, 8'hC0, 8, ok);
        if (!ok) return;
        beats = 0;
        for (int t = 1; t <= 10 && beats < 2; t++) begin
            if (rd_valid) beats++;
            if (beats < 2) step();
        end
        reset = 1'b0;
        step();
        vectors++;
        if ({rd_valid, rd_data, busy, ce_mem, we_mem, addr_mem,
             datai_mem, cmd_ready, wr_ready} !== '0 || beats != 2) begin
            errors++;
            $display("FAIL rst_mid: rd_valid=%b busy=%b ce=%b addr=%02h beats=%0d required zeros, 2 beats",
                     rd_valid, busy, ce_mem, addr_mem, beats);
        end
        reset = 1'b1;
        late = 0;
        for (int t = 0; t < 12; t++) begin
            if (rd_valid || busy) late++;
            step();
        end
        vectors++;
        if (late != 0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_after: stray=%0d cmd_ready=%b required 0/1",
                     late, cmd_ready);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        int n;
        for (int it = 0; it < 30; it++) begin
            a = 8'($urandom);
            n = $urandom_range(16, 1);
            if ($urandom_range(1) == 1) begin
                for (int i = 0; i < n; i++) wd[i] = 8'($urandom);
                do_write(a, n, -1, 0, 1'b1);
            end else begin
                do_read(a, n);
            end
            step();
        end
    endtask

`ifdef MEM_INIT_VERIFY_EN
    task automatic test_verify();
        for (int i = 0; i < 3; i++) wd[i] = 8'($urandom);
        do_write(8'h60, 3, -1, 0, 1'b0);
        vectors++;
        if (verify_err !== 1'b0) begin
            errors++;
            $display("FAIL vfy_clean: verify_err=%b required 0", verify_err);
        end
        corrupt_en = 1'b1;
        corrupt_addr = 8'h71;
        do_write(8'h70, 3, -1, 0, 1'b0);
        corrupt_en = 1'b0;
        vectors++;
        if (verify_err !== 1'b1) begin
            errors++;
            $display("FAIL vfy_set: verify_err=%b required 1", verify_err);
        end
        do_read(8'h70, 3);
        vectors++;
        if (verify_err !== 1'b1) begin
            errors++;
            $display("FAIL vfy_sticky: verify_err=%b required 1", verify_err);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        vectors++;
        if (verify_err !== 1'b0) begin
            errors++;
            $display("FAIL vfy_clear: verify_err=%b required 0", verify_err);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_gaps();
        test_cmd_ignored();
        test_reset_mid();
`ifdef MEM_INIT_VERIFY_EN
        test_verify();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
